// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared types and defaults for the counter family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam int CNT_WIDTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        CNT_IDLE = 1'b0,
        CNT_RUN  = 1'b1
    } cnt_state_t;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/down_counter_reload.sv
// ============================================================================
// Module : down_counter_reload
// Brief  : Loadable down counter/timer with terminal-count pulse and optional
//          auto-reload. Priority: reset > load > stop > en.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module down_counter_reload
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    cnt_state_t       r_state;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;

    cnt_state_t       w_state_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_y_nxt      = r_y;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        if (load) begin
            w_y_nxt      = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = CNT_RUN;
        end else if (r_state == CNT_RUN) begin
            if (stop) begin
                w_state_nxt = CNT_IDLE;
            end else if (en) begin
                if (r_y != '0) begin
                    w_y_nxt = r_y - c_one;
                end else begin
                    // Terminal count: y never wraps below zero, it reloads or parks.
                    w_tc_nxt = 1'b1;
                    if (auto_reload) begin
                        w_y_nxt = r_reload;
                    end else begin
                        w_state_nxt = CNT_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= CNT_IDLE;
            r_y      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_y      <= w_y_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= (w_state_nxt == CNT_RUN);
        end
    end

    assign y    = r_y;
    assign tc   = r_tc;
    assign busy = r_busy;

endmodule : down_counter_reload

`default_nettype wire

// File: tb/tb_down_counter_reload.sv
// ============================================================================
// Module : tb_down_counter_reload
// Brief  : Directed self-checking bench for down_counter_reload.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_down_counter_reload;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] y;
    logic             tc;
    logic             busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    down_counter_reload #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .stop        (stop),
        .auto_reload (auto_reload),
        .y           (y),
        .tc          (tc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b1; stop = 1'b0; auto_reload = 1'b0;
        step();
        vec_cnt++;
        if ({y, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset: y=%0d tc=%0b busy=%0b, expected y=0 tc=0 busy=0", y, tc, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vec_cnt++;
            if ({y, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
                err_cnt++;
                $display("FAIL idle_en[%0d]: y=%0d tc=%0b busy=%0b, expected y=0 tc=0 busy=0", i, y, tc, busy);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [WIDTH-1:0] ey[8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic             et[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        logic             eb[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b0; en = 1'b1; stop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            load = 1'b0;
            vec_cnt++;
            if ({y, tc, busy} !== {ey[i], et[i], eb[i]}) begin
                err_cnt++;
                $display("FAIL oneshot[%0d]: y=%0d tc=%0b busy=%0b, expected y=%0d tc=%0b busy=%0b",
                         i, y, tc, busy, ey[i], et[i], eb[i]);
            end
        end
    endtask

    task automatic test_autoreload();
        logic [WIDTH-1:0] ey[14] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1,
                                     4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd3};
        logic             et[14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        logic             eb[14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1; stop = 1'b0;
        for (int i = 0; i < 14; i++) begin
            stop = (i == 13);
            step();
            load = 1'b0;
            vec_cnt++;
            if ({y, tc, busy} !== {ey[i], et[i], eb[i]}) begin
                err_cnt++;
                $display("FAIL autoreload[%0d]: y=%0d tc=%0b busy=%0b, expected y=%0d tc=%0b busy=%0b",
                         i, y, tc, busy, ey[i], et[i], eb[i]);
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_enable_hold();
        logic             ena[13] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [WIDTH-1:0] ey[13]  = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd5, 4'd5,
                                      4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        logic             et[13]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic             eb[13]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        load = 1'b1; load_val = 4'd9; auto_reload = 1'b0; stop = 1'b0;
        for (int i = 0; i < 13; i++) begin
            en = ena[i];
            step();
            load = 1'b0;
            vec_cnt++;
            if ({y, tc, busy} !== {ey[i], et[i], eb[i]}) begin
                err_cnt++;
                $display("FAIL en_hold[%0d]: y=%0d tc=%0b busy=%0b, expected y=%0d tc=%0b busy=%0b",
                         i, y, tc, busy, ey[i], et[i], eb[i]);
            end
        end
    endtask

    task automatic test_load_restart();
        logic             ld[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        logic [WIDTH-1:0] lv[8] = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0};
        logic [WIDTH-1:0] ey[8] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd2, 4'd1, 4'd0, 4'd0};
        logic             et[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        logic             eb[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        auto_reload = 1'b0; en = 1'b1; stop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load = ld[i]; load_val = lv[i];
            step();
            vec_cnt++;
            if ({y, tc, busy} !== {ey[i], et[i], eb[i]}) begin
                err_cnt++;
                $display("FAIL restart[%0d]: y=%0d tc=%0b busy=%0b, expected y=%0d tc=%0b busy=%0b",
                         i, y, tc, busy, ey[i], et[i], eb[i]);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_stop();
        logic             sp[7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [WIDTH-1:0] ey[7] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd6, 4'd6, 4'd6};
        logic             eb[7] = '{1, 1, 1, 1, 0, 0, 0};
        load = 1'b1; load_val = 4'd9; auto_reload = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            stop = sp[i];
            step();
            load = 1'b0;
            vec_cnt++;
            if ({y, tc, busy} !== {ey[i], 1'b0, eb[i]}) begin
                err_cnt++;
                $display("FAIL stop[%0d]: y=%0d tc=%0b busy=%0b, expected y=%0d tc=0 busy=%0b",
                         i, y, tc, busy, ey[i], eb[i]);
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic             rs[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic             ld[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        logic [WIDTH-1:0] lv[10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0};
        logic [WIDTH-1:0] ey[10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd1};
        logic             et[10] = '{0, 1, 1, 1, 0, 0, 0, 1, 0, 0};
        logic             eb[10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
        auto_reload = 1'b1; en = 1'b1; stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            reset = rs[i]; load = ld[i]; load_val = lv[i];
            step();
            vec_cnt++;
            if ({y, tc, busy} !== {ey[i], et[i], eb[i]}) begin
                err_cnt++;
                $display("FAIL zero_reload[%0d]: y=%0d tc=%0b busy=%0b, expected y=%0d tc=%0b busy=%0b",
                         i, y, tc, busy, ey[i], et[i], eb[i]);
            end
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_enable_hold();
        test_load_restart();
        test_stop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_down_counter_reload

`default_nettype wire
